gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Shares one GCD unit among N requesters. Each requester offers a packed operand pair through a valid/ready port. The arbiter grants requesters round-robin, drives the GCD's input handshake and routes each 16-bit result into that requester's response register. Operands of zero are resolved locally without using the GCD. The block sits between client logic and a single GCD instance that has no output back-pressure.

## Interface
- N, 4: number of requesters (2..8)
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req_data  input  N*32  requester i operands in bits [32i+31:32i]; upper 16 bits = a, lower 16 bits = b
- req_valid  input  N  requester i offers an operand pair
- req_ready  output  N  one-hot or zero; pair i accepted this cycle
- rsp_data  output  N*16  requester i result in bits [16i+15:16i]
- rsp_valid  output  N  result slot i full
- rsp_ready  input  N  requester i consumes slot i
- gcd_in_data  output  32  operands to GCD, {a,b}
- gcd_in_valid  output  1  GCD input valid
- gcd_in_ready  input  1  GCD input ready
- gcd_out_data  input  16  GCD result
- gcd_out_valid  input  1  GCD result valid

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE.
- Eligibility: requester i is eligible when req_valid[i] is high and slot i is empty. This guarantees a result can always be captured, because the GCD cannot be stalled.
- IDLE:
  - Round-robin pick among eligible requesters, starting from pointer rr_ptr (reset 0).
  - req_ready[winner]=1 combinationally that cycle.
  - Operands are latched into op_reg and the winner into owner.
  - rr_ptr is set to (winner+1) mod N.
- Zero bypass, applied in IDLE: if a==0 or b==0, the slot gets a|b (so gcd(0,0)=0) on the next clock edge. State stays IDLE and the GCD is untouched. Otherwise the next state is ISSUE.
- ISSUE: gcd_in_valid=1 and gcd_in_data=op_reg. On gcd_in_ready, go to WAIT.
- WAIT: on gcd_out_valid, write gcd_out_data into slot[owner], set rsp_valid[owner], go to IDLE.
- gcd_out_valid is ignored outside WAIT.
- GCD contract: gcd_out_valid is low in the cycle after an input handshake, so a stale result is never captured.
- Slot i is cleared when rsp_valid[i] and rsp_ready[i] are both high. A slot can be cleared while another slot is being written in the same cycle. The same slot is never set and cleared at once, because of eligibility.
- Only one operation is outstanding at a time.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, gcd_in_valid=0, gcd_in_data=0, rr_ptr=0, owner=0.
- Normal path (request accepted in cycle t):
  - ISSUE at t+1. Handshake at the earliest cycle ≥t+1 with gcd_in_ready high.
  - WAIT begins the following cycle.
  - rsp_valid rises the cycle after gcd_out_valid is sampled in WAIT.
- Bypass path: accepted at t, rsp_valid high at t+1. IDLE can accept another request at t+1.
- After a normal result, IDLE is re-entered and the next grant can occur in that same cycle.
- No eligible requester: req_ready=0 and rr_ptr is held.
- gcd_in_valid is held, with data stable, until gcd_in_ready.
- Reset mid-operation:
  - All state and slots are cleared and the in-flight result is discarded.
  - The GCD must be reset on the same reset.

## Structure
- Package gcd_arb_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT};
  - constants OP_W=16 and PAIR_W=32;
  - MAX_N=8.
- Sub-module rr_arbiter (parameter N): inputs eligible[N] and ptr; outputs grant one-hot, grant_idx and any_grant. It is purely combinational.
- Top level: FSM, op_reg, owner, rr_ptr, N response slots.

## Test plan
- Single request, requester 0, req_data=0x0030_0020 → granted at t; GCD gets 0x0030_0020; rsp_data[0]=0x0010 with rsp_valid[0]=1; all other rsp_valid stay 0.
- All four requesters valid at once, with pairs (0x30,0x20), (0x0F,0x0A), (0x11,0x07), (0x40,0x18) → grant order 0,1,2,3; results 0x10, 0x05, 0x01, 0x08 land in their own slots.
- Zero bypass: requester 2 sends 0x0000_0015 → rsp_data[2]=0x0015 one cycle later with no gcd_in_valid pulse; 0x0000_0000 → 0x0000.
- Slot full: requester 1 holds rsp_ready=0 with its slot full and keeps req_valid=1 → it is never granted; requesters 0 and 3 alternate. Pulsing rsp_ready[1] clears the slot, and requester 1 is granted in its next round-robin turn.
- Back-pressure: gcd_in_ready low for 5 cycles in ISSUE → gcd_in_valid and data stay stable; handshake completes on the first high cycle.
- Reset asserted during WAIT → the next cycle is IDLE with all outputs at reset values; a late gcd_out_valid does not set any rsp_valid.

Source files
------------

// File: rtl/gcd_arb_pkg.sv
// Shared types and widths for the GCD arbiter.
package gcd_arb_pkg;

   localparam int unsigned OP_W   = 16;
   localparam int unsigned PAIR_W = 32;
   localparam int unsigned MAX_N  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr.
module rr_arbiter #(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_grant
);

   // Scan N positions starting at ptr and keep the first eligible one
   always_comb begin
      logic [IDX_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IDX_W'((32'(ptr) + k) % N);
         if (!any_grant && eligible[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares a single GCD unit among N requesters with per-requester result slots.
module gcd_arbiter
   import gcd_arb_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N*PAIR_W-1:0] req_data,
   input  logic [N-1:0]        req_valid,
   output logic [N-1:0]        req_ready,
   output logic [N*OP_W-1:0]   rsp_data,
   output logic [N-1:0]        rsp_valid,
   input  logic [N-1:0]        rsp_ready,
   output logic [PAIR_W-1:0]   gcd_in_data,
   output logic                gcd_in_valid,
   input  logic                gcd_in_ready,
   input  logic [OP_W-1:0]     gcd_out_data,
   input  logic                gcd_out_valid
);

   localparam int unsigned IDX_W = $clog2(N);

   state_t            state;
   state_t            state_nxt;
   logic [PAIR_W-1:0] op_reg;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  rr_ptr;
   logic [N-1:0]      eligible;
   logic [N-1:0]      grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              any_grant;
   logic              accept;
   logic              bypass;
   logic [PAIR_W-1:0] sel_pair;
   logic [OP_W-1:0]   sel_a;
   logic [OP_W-1:0]   sel_b;
   logic [N-1:0]      slot_wr;
   logic [OP_W-1:0]   slot_wdata;

   // Only requesters with an empty slot may win, so a result always has a home
   assign eligible = req_valid & ~rsp_valid;

   rr_arbiter #(.N(N)) u_rr (
      .eligible  (eligible),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Operand pair offered by the current winner
   always_comb begin
      sel_pair = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant[i]) sel_pair = req_data[i*PAIR_W +: PAIR_W];
      end
   end

   assign sel_a  = sel_pair[PAIR_W-1:OP_W];
   assign sel_b  = sel_pair[OP_W-1:0];
   assign bypass = (sel_a == '0) || (sel_b == '0);

   assign gcd_in_valid = (state == ISSUE);
   assign gcd_in_data  = op_reg;

   // Next-state and grant decode
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (any_grant) begin
               req_ready = grant;
               accept    = 1'b1;
               if (!bypass) state_nxt = ISSUE;
            end
         end
         ISSUE: if (gcd_in_ready) state_nxt = WAIT;
         WAIT:  if (gcd_out_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slot write select: zero-operand bypass in IDLE, GCD result in WAIT
   always_comb begin
      slot_wr    = '0;
      slot_wdata = sel_a | sel_b;
      if (accept && bypass) begin
         slot_wr = grant;
      end else if ((state == WAIT) && gcd_out_valid) begin
         slot_wr[owner] = 1'b1;
         slot_wdata     = gcd_out_data;
      end
   end

   // FSM state, captured operands, owner and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         op_reg <= '0;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_reg <= sel_pair;
            owner  <= grant_idx;
            rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // Response slots: set on write, cleared on consumer handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (slot_wr[i]) begin
               rsp_valid[i]                <= 1'b1;
               rsp_data[i*OP_W +: OP_W]    <= slot_wdata;
            end else if (rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter with a behavioural GCD unit and scoreboard.
module tb_gcd_arbiter;
   import gcd_arb_pkg::*;

   localparam int unsigned N = 4;

   typedef struct {
      int          req;
      logic [31:0] pair;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      int          idx;
      logic [15:0] d;
   } res_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N*32-1:0]   req_data = '0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N*16-1:0]   rsp_data;
   logic [N-1:0]      rsp_valid;
   logic [N-1:0]      rsp_ready;
   logic [31:0]       gcd_in_data;
   logic              gcd_in_valid;
   logic              gcd_in_ready;
   logic [15:0]       gcd_out_data;
   logic              gcd_out_valid;

   int total = 0;
   int bad   = 0;

   logic [N-1:0] rsp_man = '0;
   logic [N-1:0] rnd_rsp = '0;
   bit           rand_en = 1'b0;
   bit           ready_block = 1'b0;
   bit           rnd_block = 1'b0;
   int           gcd_lat = 2;
   logic         inj_valid = 1'b0;
   logic [15:0]  inj_data = '0;

   logic [31:0]  src_q [N][$];
   logic [15:0]  exp_q [N][$];
   int           grant_log [$];
   res_t         res_log [$];
   int           m_ptr = 0;
   logic [N-1:0] prev_rv = '0;
   int           iv_cycles = 0;
   logic [N-1:0] drv_acc;

   int           g_cnt = 0;
   logic [15:0]  g_res = '0;
   logic         m_out_valid = 1'b0;
   logic [15:0]  m_out_data = '0;

   gcd_arbiter #(.N(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .rsp_data      (rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .gcd_in_data   (gcd_in_data),
      .gcd_in_valid  (gcd_in_valid),
      .gcd_in_ready  (gcd_in_ready),
      .gcd_out_data  (gcd_out_data),
      .gcd_out_valid (gcd_out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_gcd(input logic [15:0] a_in, input logic [15:0] b_in);
      logic [15:0] x, y, t;
      x = a_in;
      y = b_in;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic logic [31:0] rand_pair();
      logic [15:0] g, a, b;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      g = 16'($urandom_range(1, 40));
      a = g * 16'($urandom_range(1, 200));
      b = g * 16'($urandom_range(1, 200));
      if (sel == 0) a = '0;
      else if (sel == 1) b = '0;
      else if (sel == 2) begin a = '0; b = '0; end
      return {a, b};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_grant(input int i, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (req_ready[i]) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_rsp(input int i, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (rsp_valid[i]) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_in_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (gcd_in_valid) begin ok = 1'b1; break; end
      end
   endtask

   assign rsp_ready     = rsp_man | rnd_rsp;
   assign gcd_in_ready  = (g_cnt == 0) && !ready_block && !rnd_block;
   assign gcd_out_valid = m_out_valid | inj_valid;
   assign gcd_out_data  = inj_valid ? inj_data : m_out_data;

   // Behavioural GCD unit: fixed or random latency, no output back-pressure
   always @(posedge clk) begin
      if (reset) begin
         g_cnt       <= 0;
         m_out_valid <= 1'b0;
      end else begin
         m_out_valid <= 1'b0;
         if (gcd_in_valid && gcd_in_ready) begin
            g_cnt <= rand_en ? int'($urandom_range(1, 6)) : gcd_lat;
            g_res <= ref_gcd(gcd_in_data[31:16], gcd_in_data[15:0]);
         end else if (g_cnt == 1) begin
            m_out_valid <= 1'b1;
            m_out_data  <= g_res;
            g_cnt       <= 0;
         end else if (g_cnt > 1) begin
            g_cnt <= g_cnt - 1;
         end
      end
   end

   // Random back-pressure on the GCD input and on the response consumers
   always @(posedge clk) begin
      rnd_block <= rand_en && ($urandom_range(0, 3) == 0);
      rnd_rsp   <= rand_en ? N'($urandom) : '0;
   end

   // Requester drivers: present queue heads, pop on acceptance
   always @(posedge clk) begin
      drv_acc = req_ready & {N{~reset}};
      #1;
      for (int i = 0; i < N; i++) begin
         if (drv_acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         req_valid[i]         = (src_q[i].size() > 0);
         req_data[i*32 +: 32] = req_valid[i] ? src_q[i][0] : 32'h0;
      end
   end

   // Scoreboard: round-robin rule, single outstanding op, per-slot results
   always @(negedge clk) begin
      int w, ew, outst, idx;
      logic [31:0] pr;
      if (reset) begin
         m_ptr   = 0;
         prev_rv = '0;
         for (int i = 0; i < N; i++) exp_q[i].delete();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && !prev_rv[i]) begin
               check("rsp_pending", 32'(exp_q[i].size() != 0), 1);
               if (exp_q[i].size() != 0) check("rsp_data", 32'(rsp_data[i*16 +: 16]), 32'(exp_q[i].pop_front()));
               res_log.push_back('{idx: i, d: rsp_data[i*16 +: 16]});
            end
         end
         prev_rv = rsp_valid;
         check("ready_onehot0", 32'($onehot0(req_ready)), 1);
         if (req_ready != '0) begin
            w = 0;
            for (int k = 0; k < N; k++) if (req_ready[k]) w = k;
            ew = -1;
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (ew < 0 && req_valid[idx] && !rsp_valid[idx]) ew = idx;
            end
            check("rr_winner", w, ew);
            outst = 0;
            for (int i = 0; i < N; i++) outst += exp_q[i].size();
            check("one_outstanding", outst, 0);
            pr = req_data[w*32 +: 32];
            exp_q[w].push_back(ref_gcd(pr[31:16], pr[15:0]));
            grant_log.push_back(w);
            m_ptr = (w + 1) % N;
         end
         if (gcd_in_valid) iv_cycles++;
      end
   end

   initial begin
      bit ok;
      int cnt, ivc, outst;
      logic [31:0] held;
      logic any;
      vec_t tab [6];

      tab[0] = '{req: 0, pair: 32'h0030_0020, exp: 16'h0010};
      tab[1] = '{req: 1, pair: 32'h000F_000A, exp: 16'h0005};
      tab[2] = '{req: 2, pair: 32'h0011_0007, exp: 16'h0001};
      tab[3] = '{req: 3, pair: 32'h0040_0018, exp: 16'h0008};
      tab[4] = '{req: 2, pair: 32'h0000_0015, exp: 16'h0015};
      tab[5] = '{req: 2, pair: 32'h0000_0000, exp: 16'h0000};

      // Reset values
      repeat (3) tick();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", rsp_data[31:0] | rsp_data[63:32], 0);
      check("rst_in_valid", 32'(gcd_in_valid), 0);
      check("rst_in_data", gcd_in_data, 0);
      tick();
      reset = 1'b0;

      // Single request on requester 0
      gcd_lat = 3;
      tick();
      src_q[0].push_back(tab[0].pair);
      wait_grant(0, 5, ok);
      check("single_grant", 32'(ok), 1);
      check("single_ready", 32'(req_ready), 32'h1);
      wait_in_valid(5, ok);
      check("single_issue", 32'(ok), 1);
      check("single_in_data", gcd_in_data, 32'h0030_0020);
      wait_rsp(0, 50, ok);
      check("single_rsp", 32'(ok), 1);
      check("single_rsp_data", 32'(rsp_data[15:0]), 32'h0010);
      check("single_rsp_valid", 32'(rsp_valid), 32'h1);
      rsp_man = '1;
      tick();
      tick();

      // All four requesters at once from a fresh pointer
      reset = 1'b1;
      tick();
      reset = 1'b0;
      grant_log.delete();
      res_log.delete();
      for (int k = 0; k < 4; k++) src_q[tab[k].req].push_back(tab[k].pair);
      for (int k = 0; k < 300 && res_log.size() < 4; k++) @(negedge clk);
      check("all4_count", res_log.size(), 4);
      if (res_log.size() >= 4 && grant_log.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            check("all4_grant_order", grant_log[k], tab[k].req);
            check("all4_res_idx", res_log[k].idx, tab[k].req);
            check("all4_res_data", 32'(res_log[k].d), 32'(tab[k].exp));
         end
      end

      // Zero-operand bypass on requester 2
      tick();
      rsp_man = 4'b1011;
      for (int k = 4; k < 6; k++) begin
         tick();
         src_q[2].push_back(tab[k].pair);
         ivc = iv_cycles;
         wait_grant(2, 5, ok);
         check("byp_grant", 32'(ok), 1);
         @(negedge clk);
         check("byp_valid", 32'(rsp_valid[2]), 1);
         check("byp_data", 32'(rsp_data[47:32]), 32'(tab[k].exp));
         check("byp_no_issue", iv_cycles, ivc);
         rsp_man[2] = 1'b1;
         tick();
         rsp_man[2] = 1'b0;
      end

      // Full slot on requester 1 blocks its grants
      rsp_man = 4'b1111;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rsp_man = 4'b1101;
      gcd_lat = 1;
      src_q[1].push_back(32'h0015_0006);
      wait_rsp(1, 50, ok);
      check("full_fill", 32'(ok), 1);
      tick();
      grant_log.delete();
      for (int k = 0; k < 3; k++) begin
         src_q[0].push_back(rand_pair());
         src_q[3].push_back(rand_pair());
      end
      src_q[1].push_back(32'h0009_0006);
      for (int k = 0; k < 300 && (src_q[0].size() + src_q[3].size()) != 0; k++) @(negedge clk);
      repeat (10) @(negedge clk);
      check("full_grant_count", grant_log.size(), 6);
      cnt = 0;
      foreach (grant_log[k]) if (grant_log[k] == 1) cnt++;
      check("full_no_grant1", cnt, 0);
      rsp_man[1] = 1'b1;
      tick();
      rsp_man[1] = 1'b0;
      wait_grant(1, 5, ok);
      check("full_regrant", 32'(ok), 1);
      rsp_man = '1;
      repeat (10) tick();

      // Back-pressure on the GCD input
      ready_block = 1'b1;
      gcd_lat = 2;
      tick();
      src_q[3].push_back(32'h0100_0040);
      wait_in_valid(10, ok);
      check("bp_issue", 32'(ok), 1);
      held = gcd_in_data;
      check("bp_data", held, 32'h0100_0040);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_stable", 32'(gcd_in_valid && (gcd_in_data == held)), 1);
      end
      ready_block = 1'b0;
      @(negedge clk);
      check("bp_handshake", 32'(gcd_in_valid), 0);
      wait_rsp(3, 50, ok);
      check("bp_rsp", 32'(ok), 1);
      repeat (3) tick();

      // Reset while waiting on the GCD result
      gcd_lat = 10;
      tick();
      src_q[0].push_back(32'h0030_0020);
      wait_in_valid(10, ok);
      check("rw_issue", 32'(ok), 1);
      for (int k = 0; k < 10 && gcd_in_valid; k++) @(negedge clk);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rw_req_ready", 32'(req_ready), 0);
      check("rw_rsp_valid", 32'(rsp_valid), 0);
      check("rw_in_valid", 32'(gcd_in_valid), 0);
      check("rw_in_data", gcd_in_data, 0);
      inj_data  = 16'h0010;
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      any = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         any = any | (|rsp_valid);
      end
      check("rw_no_stale", 32'(any), 0);

      // Randomized traffic against the scoreboard
      rsp_man = '0;
      rand_en = 1'b1;
      tick();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 25; k++) src_q[i].push_back(rand_pair());
      ok = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         outst = 0;
         for (int i = 0; i < N; i++) outst += src_q[i].size() + exp_q[i].size();
         if (outst == 0) begin ok = 1'b1; break; end
      end
      check("rand_drained", 32'(ok), 1);
      rand_en = 1'b0;
      rsp_man = '1;
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
